rib_wr_buf: RTL and testbench
=============================

Name: rib_wr_buf

Overview:
- Posted-write buffer between the core's data-side bus port (addr/data/req/we/ack) and the RIB master port.
- Writes from the execute stage are accepted into a small FIFO and acknowledged after 1 cycle; they then drain to the bus in the background.
- Reads wait until all buffered writes have drained, then issue on the bus, preserving program order.
- wb_empty_o lets control logic hold the pipeline for fence/halt until the buffer is empty.

Parameters:
DEPTH, 4, write-buffer entries; power of 2, minimum 2
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
core_addr_i  in  ADDR_W  access address from execute stage
core_data_i  in  DATA_W  write data from execute stage
core_req_i  in  1  access request, level, held until core_ack_o
core_we_i  in  1  1=write, 0=read
core_data_o  out  DATA_W  read data, valid while core_ack_o=1
core_ack_o  out  1  one-cycle access completion pulse
bus_addr_o  out  ADDR_W  RIB address
bus_data_o  out  DATA_W  RIB write data
bus_req_o  out  1  RIB request, held until bus_ack_i
bus_we_o  out  1  RIB write enable
bus_data_i  in  DATA_W  RIB read data, valid with bus_ack_i
bus_ack_i  in  1  RIB completion, single-cycle pulse
wb_empty_o  out  1  1 when FIFO is empty and no bus write is outstanding

Behaviour:
- Reset (rst=0, async): FIFO pointers cleared; all buffered writes discarded; FSM=IDLE.
  - Output reset values: core_ack_o=0, core_data_o=0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_data_o=0, wb_empty_o=1.
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits; wrap modulo 2*DEPTH.
  - full = MSBs differ and lower bits equal; empty = pointers equal.
  - Entry holds {addr, data}.
- Accept rule: core request sampled when core_req_i=1, FSM=IDLE and core_ack_o=0.
  - core_ack_o=1 blocks re-sampling of a request still held high in its ack cycle.
- Write accept:
  - Enqueue when core_we_i=1 and not full.
  - core_ack_o pulses the next cycle (latency 1).
  - Full: not accepted; request stays pending with no ack.
  - Full is evaluated on registered pointers: a pop in the same cycle does not admit the write until the next cycle.
- Drain side (independent of accept):
  - When FIFO is non-empty and the bus is idle, present the head entry: bus_req_o=1, bus_we_o=1, addr/data registered.
  - bus_addr_o, bus_data_o and bus_we_o stay stable until bus_ack_i.
  - On bus_ack_i: pop the head; bus_req_o=0 for at least 1 cycle before the next request.
- Read FSM:
  - IDLE -> DRAIN on an accepted read (core_we_i=0); latch the read address.
  - DRAIN -> RD when the FIFO is empty and no bus write is outstanding. Exits the same cycle the condition is met, so an already-empty buffer costs 1 cycle.
  - RD: bus_req_o=1, bus_we_o=0, bus_addr_o=latched address; hold until bus_ack_i.
  - On bus_ack_i: register bus_data_i into core_data_o; core_ack_o=1 the next cycle; -> IDLE.
  - Minimum read latency: 3 cycles from accept to core_ack_o with zero-wait bus.
  - core_data_o holds its value until the next read completes.
- Writes cannot be accepted while FSM != IDLE.
- wb_empty_o is registered; it drops the cycle after an enqueue and rises the cycle after the last pop's ack.

Optional Feature:
- Macro WB_RD_FWD_EN.
- Defined:
  - A read whose address equals any buffered entry's address returns the youngest matching entry's data; core_ack_o fires the next cycle.
  - No drain and no bus read; FSM stays IDLE.
  - A matching entry currently being written on the bus is eligible.
- Undefined: all reads take the drain path; no compare logic is synthesized.

Test Plan:
- Reset mid-operation:
  - Stimulus: 3 writes buffered, bus_ack_i withheld, then rst=0 for 1 cycle.
  - Response: bus_req_o=0 and wb_empty_o=1 immediately; no further bus writes after release.
- Write burst, DEPTH=4, bus_ack_i tied 0:
  - Stimulus: 5 writes to 0x1000..0x1010.
  - Response: 4 acks, each 1 cycle after accept; 5th held without ack.
  - Then pulse bus_ack_i: 5th accepted 1 cycle after the pop; bus order is 0x1000, 0x1004, ...
- Read-after-write, zero-wait bus:
  - Stimulus: write 0xDEADBEEF to 0x2000, then read 0x3000.
  - Response: bus write to 0x2000 is acked before the bus read of 0x3000 begins; core_data_o = bus_data_i value.
- Idle read, empty buffer, zero-wait bus:
  - Stimulus: read 0x4000.
  - Response: core_ack_o exactly 3 cycles after accept.
- Pointer wrap:
  - Stimulus: 10 sequential write/drain cycles with random 0–3-cycle bus ack delays.
  - Response: all 10 addr/data pairs appear on the bus in order; wb_empty_o=1 at end.
- WB_RD_FWD_EN defined:
  - Stimulus: write 0x11 then 0x22 to 0x5000 with bus stalled, then read 0x5000.
  - Response: core_data_o=0x22 one cycle after accept; no bus read issued.

Source files
------------

// File: rtl/rib_wr_buf.sv
// rib_wr_buf: posted-write buffer between the core data port and the RIB master; define WB_RD_FWD_EN to forward reads from buffered writes
module rib_wr_buf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_ack_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i,
  output logic              wb_empty_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DRAIN, RD} state_t;
  state_t            r_state;
  logic [AW:0]       r_wp, r_rp;
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_bus_wr;
  logic              w_full, w_empty, w_accept, w_push, w_pop, w_issue;
  logic              w_fwd, w_rd_start, w_rd_done, w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic [AW:0]       w_wp_n, w_rp_n;
  assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_empty    = r_wp == r_rp;
  assign w_accept   = core_req_i && r_state == IDLE && !core_ack_o;
  assign w_push     = w_accept && core_we_i && !w_full;
  assign w_fwd      = w_accept && !core_we_i && w_hit;
  assign w_rd_start = w_accept && !core_we_i && !w_hit;
  assign w_rd_done  = r_state == RD && bus_ack_i;
  assign w_pop      = bus_ack_i && r_bus_wr;
  assign w_issue    = !w_empty && !bus_req_o;
  assign w_wp_n     = r_wp + (AW+1)'(w_push);
  assign w_rp_n     = r_rp + (AW+1)'(w_pop);
`ifdef WB_RD_FWD_EN
  logic [AW:0] w_cnt;
  // scan oldest to youngest so the youngest matching entry wins; the head in flight on the bus still counts
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_cnt      = r_wp - r_rp;
    for (int i = 0; i < DEPTH; i++)
      if ((AW+1)'(i) < w_cnt && r_mem_addr[r_rp[AW-1:0] + AW'(i)] == core_addr_i) begin
        w_hit      = 1'b1;
        w_hit_data = r_mem_data[r_rp[AW-1:0] + AW'(i)];
      end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif
  // buffer storage needs no reset: validity comes from the pointers
  always_ff @(posedge clk)
    if (w_push) begin
      r_mem_addr[r_wp[AW-1:0]] <= core_addr_i;
      r_mem_data[r_wp[AW-1:0]] <= core_data_i;
    end
  // pointers, core handshake, bus master and read sequencing
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= IDLE;
      r_wp        <= '0;
      r_rp        <= '0;
      r_rd_addr   <= '0;
      r_bus_wr    <= 1'b0;
      core_ack_o  <= 1'b0;
      core_data_o <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_data_o  <= '0;
      wb_empty_o  <= 1'b1;
    end else begin
      r_wp       <= w_wp_n;
      r_rp       <= w_rp_n;
      wb_empty_o <= (w_wp_n == w_rp_n) && !(r_bus_wr && !w_pop);
      core_ack_o <= w_push || w_fwd || w_rd_done;
      if (w_fwd || w_rd_done) core_data_o <= w_fwd ? w_hit_data : bus_data_i;
      if (w_rd_start) r_rd_addr <= core_addr_i;
      if (w_issue) begin
        bus_req_o  <= 1'b1;
        bus_we_o   <= 1'b1;
        bus_addr_o <= r_mem_addr[r_rp[AW-1:0]];
        bus_data_o <= r_mem_data[r_rp[AW-1:0]];
        r_bus_wr   <= 1'b1;
      end else if (r_state == DRAIN && wb_empty_o) begin
        bus_req_o  <= 1'b1;
        bus_we_o   <= 1'b0;
        bus_addr_o <= r_rd_addr;
      end else if (bus_ack_i && bus_req_o) begin
        bus_req_o <= 1'b0;
        r_bus_wr  <= 1'b0;
      end
      r_state <= w_rd_start ? DRAIN :
                 (r_state == DRAIN && wb_empty_o) ? RD :
                 w_rd_done ? IDLE : r_state;
    end
endmodule

// File: tb/tb_rib_wr_buf.sv
// tb_rib_wr_buf: directed checks of the posted-write buffer against hand-computed expectations
module tb_rib_wr_buf;
  logic        clk, rst;
  logic [31:0] core_addr_i, core_data_i, core_data_o;
  logic        core_req_i, core_we_i, core_ack_o;
  logic [31:0] bus_addr_o, bus_data_o, bus_data_i;
  logic        bus_req_o, bus_we_o, bus_ack_i, wb_empty_o;
  int total = 0, bad = 0;
  logic [31:0] la[$], ld[$];
  logic        lw[$];
  logic man_ack = 0;
  bit   bus_en = 0, rnd = 0;
  int   dly = 0, wcnt = 0;

  rib_wr_buf dut (
    .clk(clk), .rst(rst),
    .core_addr_i(core_addr_i), .core_data_i(core_data_i), .core_req_i(core_req_i),
    .core_we_i(core_we_i), .core_data_o(core_data_o), .core_ack_o(core_ack_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
    .wb_empty_o(wb_empty_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  assign bus_ack_i = man_ack || (bus_en && bus_req_o && wcnt >= dly);

  // bus slave: logs every completed transfer, optional random wait states
  always @(posedge clk) begin
    if (bus_req_o && bus_ack_i) begin
      la.push_back(bus_addr_o);
      ld.push_back(bus_data_o);
      lw.push_back(bus_we_o);
      wcnt <= 0;
      dly  <= rnd ? int'($urandom_range(0, 3)) : 0;
    end else if (bus_req_o) wcnt <= wcnt + 1;
  end

  task automatic core_access(input logic we, input logic [31:0] a, input logic [31:0] d, output int lat);
    core_req_i = 1; core_we_i = we; core_addr_i = a; core_data_i = d; lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (core_ack_o) begin lat = c; break; end
    end
    core_req_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(output bit ok);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (wb_empty_o && !bus_req_o) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1; #2 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (core_ack_o !== 1'b0) begin bad++; $display("FAIL rst_core_ack got %b want 0", core_ack_o); end
    total++; if (core_data_o !== 32'h0) begin bad++; $display("FAIL rst_core_data got %h want 0", core_data_o); end
    total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL rst_bus_req got %b want 0", bus_req_o); end
    total++; if (bus_we_o !== 1'b0) begin bad++; $display("FAIL rst_bus_we got %b want 0", bus_we_o); end
    total++; if (bus_addr_o !== 32'h0) begin bad++; $display("FAIL rst_bus_addr got %h want 0", bus_addr_o); end
    total++; if (bus_data_o !== 32'h0) begin bad++; $display("FAIL rst_bus_data got %h want 0", bus_data_o); end
    total++; if (wb_empty_o !== 1'b1) begin bad++; $display("FAIL rst_wb_empty got %b want 1", wb_empty_o); end
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    int lat, b;
    bus_en = 0;
    for (int i = 0; i < 3; i++) core_access(1, 32'h7000 + 32'(4*i), 32'h70 + 32'(i), lat);
    total++; if (bus_req_o !== 1'b1 || wb_empty_o !== 1'b0) begin bad++; $display("FAIL midop_busy got req=%b empty=%b want req=1 empty=0", bus_req_o, wb_empty_o); end
    rst = 0; #1;
    total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL midop_rst_req got %b want 0", bus_req_o); end
    total++; if (wb_empty_o !== 1'b1) begin bad++; $display("FAIL midop_rst_empty got %b want 1", wb_empty_o); end
    @(posedge clk); #1;
    rst = 1;
    b = la.size(); bus_en = 1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (la.size() !== b) begin bad++; $display("FAIL midop_no_bus got %0d transfers want 0", la.size() - b); end
    total++; if (wb_empty_o !== 1'b1) begin bad++; $display("FAIL midop_empty_after got %b want 1", wb_empty_o); end
  endtask

  task automatic test_burst;
    int lat, b;
    bit acked, ok;
    bus_en = 0; b = la.size();
    for (int i = 0; i < 4; i++) begin
      core_access(1, 32'h1000 + 32'(4*i), 32'hB0 + 32'(i), lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL burst_ack_lat%0d got %0d want 1", i, lat); end
    end
    core_req_i = 1; core_we_i = 1; core_addr_i = 32'h1010; core_data_i = 32'hB4; acked = 0;
    repeat (4) begin @(posedge clk); #1; if (core_ack_o) acked = 1; end
    total++; if (acked !== 1'b0) begin bad++; $display("FAIL burst_full_held got ack=%b want 0", acked); end
    total++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h1000) begin bad++; $display("FAIL burst_head got req=%b addr=%h want 1/00001000", bus_req_o, bus_addr_o); end
    man_ack = 1; @(posedge clk); #1; man_ack = 0;
    total++; if (core_ack_o !== 1'b0) begin bad++; $display("FAIL burst_pop_same_cycle got ack=%b want 0", core_ack_o); end
    total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL burst_req_gap got %b want 0", bus_req_o); end
    @(posedge clk); #1;
    total++; if (core_ack_o !== 1'b1) begin bad++; $display("FAIL burst_5th_ack got %b want 1", core_ack_o); end
    core_req_i = 0;
    @(posedge clk); #1;
    bus_en = 1; wait_empty(ok);
    total++; if (!ok) begin bad++; $display("FAIL burst_drain_timeout got empty=%b want 1", wb_empty_o); end
    total++; if (la.size() - b !== 5) begin bad++; $display("FAIL burst_count got %0d want 5", la.size() - b); end
    for (int i = 0; i < 5 && b + i < la.size(); i++) begin
      total++;
      if (la[b+i] !== 32'h1000 + 32'(4*i) || ld[b+i] !== 32'hB0 + 32'(i) || lw[b+i] !== 1'b1) begin
        bad++; $display("FAIL burst_order%0d got %h/%h/%b want %h/%h/1", i, la[b+i], ld[b+i], lw[b+i], 32'h1000 + 32'(4*i), 32'hB0 + 32'(i));
      end
    end
  endtask

  task automatic test_raw;
    int lat, b;
    bus_en = 1; rnd = 0; bus_data_i = 32'h12345678; b = la.size();
    core_access(1, 32'h2000, 32'hDEADBEEF, lat);
    core_access(0, 32'h3000, 32'h0, lat);
    total++; if (lat <= 0) begin bad++; $display("FAIL raw_read_timeout got lat=%0d want >0", lat); end
    total++; if (la.size() - b !== 2) begin bad++; $display("FAIL raw_count got %0d want 2", la.size() - b); end
    if (la.size() - b >= 2) begin
      total++; if (la[b] !== 32'h2000 || ld[b] !== 32'hDEADBEEF || lw[b] !== 1'b1) begin bad++; $display("FAIL raw_first got %h/%h/%b want 00002000/deadbeef/1", la[b], ld[b], lw[b]); end
      total++; if (la[b+1] !== 32'h3000 || lw[b+1] !== 1'b0) begin bad++; $display("FAIL raw_second got %h/%b want 00003000/0", la[b+1], lw[b+1]); end
    end
    total++; if (core_data_o !== 32'h12345678) begin bad++; $display("FAIL raw_data got %h want 12345678", core_data_o); end
  endtask

  task automatic test_idle_read;
    int lat, b;
    bit ok;
    bus_en = 1; rnd = 0; bus_data_i = 32'hA1B2C3D4; b = la.size();
    core_access(0, 32'h4000, 32'h0, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL idle_rd_lat got %0d want 3", lat); end
    total++; if (core_data_o !== 32'hA1B2C3D4) begin bad++; $display("FAIL idle_rd_data got %h want a1b2c3d4", core_data_o); end
    total++; if (la.size() - b !== 1 || la[b] !== 32'h4000 || lw[b] !== 1'b0) begin bad++; $display("FAIL idle_rd_bus got n=%0d want one read of 00004000", la.size() - b); end
    bus_data_i = 32'h0BADF00D;
    core_access(1, 32'h4100, 32'h55, lat);
    wait_empty(ok);
    total++; if (core_data_o !== 32'hA1B2C3D4) begin bad++; $display("FAIL rd_data_hold got %h want a1b2c3d4", core_data_o); end
  endtask

  task automatic test_wrap;
    int lat, b;
    bit ok;
    bus_en = 1; rnd = 1; b = la.size();
    for (int i = 0; i < 10; i++) begin
      core_access(1, 32'h6000 + 32'(4*i), 32'hA5000000 + 32'(i), lat);
      total++; if (lat <= 0) begin bad++; $display("FAIL wrap_ack%0d got lat=%0d want >0", i, lat); end
    end
    wait_empty(ok);
    rnd = 0;
    total++; if (!ok || wb_empty_o !== 1'b1) begin bad++; $display("FAIL wrap_empty got %b want 1", wb_empty_o); end
    total++; if (la.size() - b !== 10) begin bad++; $display("FAIL wrap_count got %0d want 10", la.size() - b); end
    for (int i = 0; i < 10 && b + i < la.size(); i++) begin
      total++;
      if (la[b+i] !== 32'h6000 + 32'(4*i) || ld[b+i] !== 32'hA5000000 + 32'(i)) begin
        bad++; $display("FAIL wrap_order%0d got %h/%h want %h/%h", i, la[b+i], ld[b+i], 32'h6000 + 32'(4*i), 32'hA5000000 + 32'(i));
      end
    end
  endtask

`ifdef WB_RD_FWD_EN
  task automatic test_fwd;
    int lat, b;
    bit ok;
    bus_en = 0; bus_data_i = 32'hFFFFFFFF;
    core_access(1, 32'h5000, 32'h11, lat);
    core_access(1, 32'h5000, 32'h22, lat);
    b = la.size();
    core_access(0, 32'h5000, 32'h0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL fwd_lat got %0d want 1", lat); end
    total++; if (core_data_o !== 32'h22) begin bad++; $display("FAIL fwd_data got %h want 00000022", core_data_o); end
    bus_en = 1; wait_empty(ok);
    total++; if (la.size() - b !== 2 || lw[b] !== 1'b1 || lw[b+1] !== 1'b1) begin bad++; $display("FAIL fwd_no_bus_read got n=%0d want two writes", la.size() - b); end
  endtask
`endif

  initial begin
    core_req_i = 0; core_we_i = 0; core_addr_i = 0; core_data_i = 0; bus_data_i = 0;
    test_reset;
    test_reset_midop;
    test_burst;
    test_raw;
    test_idle_read;
    test_wrap;
`ifdef WB_RD_FWD_EN
    test_fwd;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
